// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Operands are latched as magnitudes
// plus sign flags, then 32 radix-2 steps run on one shared 64-bit accumulator:
// shift-add for multiply, restoring division for divide. Signs are applied in
// the step that enters DONE. Divide-by-zero and signed overflow bypass the
// iteration entirely and finish one cycle after start.
//
// state  | meaning
// IDLE   | waiting for start; flush drops a pending start
// CALC   | one radix-2 step per cycle, 32 steps
// DONE   | single-cycle result pulse, write-back strobe
module muldiv_unit #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [XLEN-1:0]   result,
  output logic [REG_AW-1:0] wb_addr,
  output logic              wb_we
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [XLEN-1:0]     mag_a_q, mag_a_d;
  logic [XLEN-1:0]     mag_b_q, mag_b_d;
  logic                sign_a_q, sign_a_d;
  logic                sign_b_q, sign_b_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic                done_q, done_d;
  logic                wb_we_q, wb_we_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [REG_AW-1:0]   wb_addr_q, wb_addr_d;

  // Operand decode at the start edge
  logic                in_sign_a, in_sign_b;
  logic [XLEN-1:0]     in_mag_a, in_mag_b;
  logic                in_div0, in_ovf;
  logic [XLEN-1:0]     special_res;

  assign in_sign_a = rs1_data[XLEN-1] &
                     ((op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110));
  assign in_sign_b = rs2_data[XLEN-1] &
                     ((op == 3'b001) || (op == 3'b100) || (op == 3'b110));
  assign in_mag_a  = in_sign_a ? -rs1_data : rs1_data;
  assign in_mag_b  = in_sign_b ? -rs2_data : rs2_data;
  assign in_div0   = op[2] && (rs2_data == '0);
  assign in_ovf    = op[2] && !op[0] &&
                     (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
  // op[1] separates REM/REMU from DIV/DIVU
  assign special_res = op[1] ? (in_div0 ? rs1_data : '0)
                             : (in_div0 ? '1 : {1'b1, {(XLEN-1){1'b0}}});

  // Multiply step: multiplier sits in the low half and shifts out LSB first
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_next;
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // Divide step: partial remainder high, dividend shifting out of the low half
  // while quotient bits shift in at the bottom
  logic [XLEN:0]       div_rem_sh;
  logic                div_ge;
  logic [XLEN-1:0]     div_rem_new;
  logic [2*XLEN-1:0]   div_next;
  assign div_rem_sh  = acc_q[2*XLEN-1:XLEN-1];
  assign div_ge      = div_rem_sh >= {1'b0, mag_b_q};
  // The partial remainder is always below the divisor, so it fits XLEN bits
  assign div_rem_new = XLEN'(div_ge ? (div_rem_sh - {1'b0, mag_b_q}) : div_rem_sh);
  assign div_next    = {div_rem_new, acc_q[XLEN-2:0], div_ge};

  logic [2*XLEN-1:0]   acc_step;
  assign acc_step = op_q[2] ? div_next : mul_next;

  // Sign fix-up applied to the value produced by the final step
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quo_fix, rem_fix, final_res;
  assign prod_fix  = (sign_a_q ^ sign_b_q) ? -acc_step : acc_step;
  assign quo_fix   = (sign_a_q ^ sign_b_q) ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
  assign rem_fix   = sign_a_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
  assign final_res = op_q[2] ? (op_q[1] ? rem_fix : quo_fix)
                             : ((op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0]
                                                     : prod_fix[2*XLEN-1:XLEN]);

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    mag_a_d   = mag_a_q;
    mag_b_d   = mag_b_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    done_d    = 1'b0;
    wb_we_d   = 1'b0;
    result_d  = result_q;
    wb_addr_d = wb_addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (!flush && start) begin
          op_d      = op;
          wb_addr_d = rd_addr;
          sign_a_d  = in_sign_a;
          sign_b_d  = in_sign_b;
          mag_a_d   = in_mag_a;
          mag_b_d   = in_mag_b;
          cnt_d     = '0;
          acc_d     = {{XLEN{1'b0}}, (op[2] ? in_mag_a : in_mag_b)};
          if (in_div0 || in_ovf) begin
            state_d  = S_DONE;
            result_d = special_res;
            done_d   = 1'b1;
            wb_we_d  = (rd_addr != '0);
          end else begin
            state_d  = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_STEP) begin
            state_d  = S_DONE;
            result_d = final_res;
            done_d   = 1'b1;
            wb_we_d  = (wb_addr_q != '0);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      done_q    <= 1'b0;
      wb_we_q   <= 1'b0;
      result_q  <= '0;
      wb_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      mag_a_q   <= mag_a_d;
      mag_b_q   <= mag_b_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      done_q    <= done_d;
      wb_we_q   <= wb_we_d;
      result_q  <= result_d;
      wb_addr_q <= wb_addr_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign wb_we   = wb_we_q;
  assign result  = result_q;
  assign wb_addr = wb_addr_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, randomized ops
// against an arithmetic reference model, and hand-written sequences for
// ignored start, flush and asynchronous reset.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_addr;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  wb_addr;
  logic        wb_we;

  int n_chk  = 0;
  int n_fail = 0;

  muldiv_unit #(.XLEN(32), .REG_AW(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rd_addr  (rd_addr),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .wb_addr  (wb_addr),
    .wb_we    (wb_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: RV32M semantics from plain 64-bit arithmetic
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, ua, ub, r;
    sa = $signed(a);
    sb = $signed(b);
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f)
      3'd0: r = ua * ub;
      3'd1: r = (sa * sb) >>> 32;
      3'd2: r = (sa * ub) >>> 32;
      3'd3: r = longint'((64'(ua) * 64'(ub)) >> 32);
      3'd4: r = (b == 0) ? -1 : sa / sb;
      3'd5: r = (b == 0) ? -1 : ua / ub;
      3'd6: r = (b == 0) ? sa : sa % sb;
      default: r = (b == 0) ? ua : ua % ub;
    endcase
    return r[31:0];
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] b);
    if (f[2] && (b == 0)) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issue one op and wait (bounded) for its done pulse; lat=0 means timeout
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] res, output int lat,
                        output logic [4:0] wa, output logic we, output logic single);
    @(negedge clk);
    start = 1'b1; op = f; rs1_data = a; rs2_data = b; rd_addr = rd;
    @(posedge clk); #1;
    start = 1'b0;
    op = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom; rd_addr = 5'($urandom);
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done) lat = 0;
    res = result; wa = wb_addr; we = wb_we;
    @(posedge clk); #1;
    single = !done && !busy;
  endtask

  task automatic check_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_res, input int exp_lat);
    logic [31:0] res;
    int          lat;
    logic [4:0]  wa;
    logic        we, single;
    run_op(f, a, b, rd, res, lat, wa, we, single);
    chk({tag, ".result"}, res, exp_res);
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".wb_addr"}, 32'(wa), 32'(rd));
    chk({tag, ".wb_we"}, 32'(we), 32'(rd != 0));
    chk({tag, ".one_cycle_done"}, 32'(single), 32'd1);
  endtask

  vec_t vecs[$];

  initial begin
    int ndone, lat_first;
    logic [2:0]  f;
    logic [31:0] a, b;
    logic [4:0]  rd;

    rst_n = 1'b0; start = 1'b0; op = '0; rs1_data = '0; rs2_data = '0;
    rd_addr = '0; flush = 1'b0;

    vecs.push_back('{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33});
    vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 33});
    vecs.push_back('{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h0000_0000, 33});
    vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'd2,          5'd8,  32'hFFFF_FFFF, 33});
    vecs.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2,          5'd9,  32'hFFFF_FFFD, 33});
    vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2,          5'd10, 32'hFFFF_FFFF, 33});
    vecs.push_back('{3'd5, 32'd100,        32'd7,          5'd11, 32'd14,        33});
    vecs.push_back('{3'd7, 32'd100,        32'd7,          5'd12, 32'd2,         33});
    vecs.push_back('{3'd5, 32'd5,          32'd0,          5'd13, 32'hFFFF_FFFF, 1});
    vecs.push_back('{3'd6, 32'd5,          32'd0,          5'd14, 32'd5,         1});
    vecs.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1});
    vecs.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h0000_0000, 1});
    vecs.push_back('{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h0000_0000, 33});
    vecs.push_back('{3'd4, 32'h8000_0000, 32'd1,          5'd18, 32'h8000_0000, 33});
    vecs.push_back('{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd0,  32'hFFFF_FFEB, 33});
    vecs.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd19, 32'h4000_0000, 33});

    // Reset state
    #12;
    chk("reset.busy", 32'(busy), 0);
    chk("reset.done", 32'(done), 0);
    chk("reset.wb_we", 32'(wb_we), 0);
    chk("reset.result", result, 0);
    chk("reset.wb_addr", 32'(wb_addr), 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      check_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd,
               vecs[i].exp_res, vecs[i].exp_lat);

    for (int i = 0; i < 48; i++) begin
      f  = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      rd = 5'($urandom);
      check_op($sformatf("rnd%0d", i), f, a, b, rd, model(f, a, b), model_lat(f, a, b));
    end

    // Start while busy is ignored: one done pulse, original op's result
    @(negedge clk);
    start = 1'b1; op = 3'd0; rs1_data = 32'd7; rs2_data = 32'hFFFF_FFFD; rd_addr = 5'd5;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; lat_first = 0;
    for (int c = 1; c <= 45; c++) begin
      if (c == 9) begin
        @(negedge clk);
        start = 1'b1; op = 3'd5; rs1_data = 32'd5; rs2_data = 32'd0; rd_addr = 5'd3;
      end else if (c == 10) begin
        @(negedge clk);
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (c == 9) chk("busy_start.busy", 32'(busy), 1);
      if (done) begin
        ndone++;
        if (lat_first == 0) lat_first = c + 1;
        chk("busy_start.result", result, 32'hFFFF_FFEB);
        chk("busy_start.wb_addr", 32'(wb_addr), 5);
      end
    end
    chk("busy_start.pulses", 32'(ndone), 1);
    chk("busy_start.latency", 32'(lat_first), 33);

    // Flush mid-DIV: idle next cycle, no pulse, previous result kept
    check_op("pre_flush", 3'd5, 32'd100, 32'd7, 5'd4, 32'd14, 33);
    @(negedge clk);
    start = 1'b1; op = 3'd4; rs1_data = 32'hFFFF_FFF9; rs2_data = 32'd2; rd_addr = 5'd7;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c < 15; c++) begin
      @(posedge clk); #1;
    end
    chk("flush.busy_before", 32'(busy), 1);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    chk("flush.busy", 32'(busy), 0);
    chk("flush.done", 32'(done), 0);
    chk("flush.wb_we", 32'(wb_we), 0);
    @(negedge clk); flush = 1'b0;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done || wb_we) ndone++;
    end
    chk("flush.pulses", 32'(ndone), 0);
    chk("flush.result", result, 32'd14);

    // Flush in IDLE outranks start
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'd5; rs1_data = 32'd1; rs2_data = 32'd0; rd_addr = 5'd2;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("idle_flush.busy", 32'(busy), 0);
    @(posedge clk); #1;
    chk("idle_flush.done", 32'(done), 0);

    // Asynchronous reset mid-CALC
    @(negedge clk);
    start = 1'b1; op = 3'd0; rs1_data = 32'd7; rs2_data = 32'd3; rd_addr = 5'd9;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst.busy", 32'(busy), 0);
    chk("async_rst.result", result, 0);
    chk("async_rst.wb_addr", 32'(wb_addr), 0);
    chk("async_rst.done", 32'(done), 0);
    @(negedge clk); rst_n = 1'b1;
    check_op("post_rst", 3'd7, 32'd100, 32'd7, 5'd1, 32'd2, 33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
